// File: rtl/pc_sequencer.sv
// PC register and next-PC selection for the multicycle CPU, with a circular
// return-address stack, alignment trap and EPC capture.
module pc_sequencer #(
    parameter int unsigned      WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [31:0]      TRAP_VECTOR  = 32'h0000_0040,
    parameter int unsigned      RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pc_write,
    input  logic [2:0]       pc_src,
    input  logic             branch_taken,
    input  logic [15:0]      offset,
    input  logic [WIDTH-1:0] reg_target,
    input  logic [25:0]      jump_index,
    input  logic             ras_push,
    input  logic             fault_clear,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] next_pc,
    output logic [WIDTH-1:0] epc,
    output logic             align_fault,
    output logic             ras_underflow,
    output logic             ras_empty,
    output logic             ras_full
);

    localparam int unsigned      PW      = $clog2(RAS_DEPTH);
    localparam int unsigned      CW      = $clog2(RAS_DEPTH + 1);
    localparam logic [WIDTH-1:0] TRAP_PC = WIDTH'(TRAP_VECTOR);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic             align_q, align_d;
    logic             under_q, under_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] stack_q [RAS_DEPTH];

    logic [PW-1:0]    top_idx;
    logic [PW-1:0]    wr_idx;
    logic [WIDTH-1:0] branch_target;
    logic [WIDTH-1:0] jump_target;
    logic             is_pop;
    logic             is_trap;
    logic             misaligned;
    logic             do_push;
    logic             do_pop;

    assign pc_plus4      = pc_q + WIDTH'(4);
    assign branch_target = pc_plus4 + {{(WIDTH-18){offset[15]}}, offset, 2'b00};
    assign jump_target   = {pc_plus4[WIDTH-1:28], jump_index, 2'b00};

    // ptr_q points at the next free slot; the top lives just below it
    assign top_idx   = ptr_q - PW'(1);
    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == CW'(RAS_DEPTH));

    assign is_pop     = (pc_src == 3'b100);
    assign is_trap    = (pc_src == 3'b110);
    assign misaligned = (next_pc[1:0] != 2'b00);
    assign do_push    = pc_write & ras_push;
    assign do_pop     = pc_write & is_pop & ~ras_empty;
    // A combined push/pop replaces the popped top in place
    assign wr_idx     = do_pop ? top_idx : ptr_q;

    always_comb begin
        next_pc = pc_plus4;
        case (pc_src)
            3'b001:  next_pc = branch_taken ? branch_target : pc_plus4;
            3'b010:  next_pc = reg_target;
            3'b011:  next_pc = jump_target;
            3'b100:  next_pc = ras_empty ? pc_plus4 : stack_q[top_idx];
            3'b110:  next_pc = TRAP_PC;
            default: next_pc = pc_plus4;
        endcase
    end

    always_comb begin
        pc_d    = pc_q;
        epc_d   = epc_q;
        align_d = align_q;
        under_d = under_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;

        if (fault_clear) begin
            align_d = 1'b0;
            under_d = 1'b0;
        end

        if (pc_write) begin
            if (misaligned) begin
                pc_d    = TRAP_PC;
                epc_d   = next_pc;
                align_d = 1'b1;
            end else if (is_trap) begin
                pc_d  = TRAP_PC;
                epc_d = pc_q;
            end else begin
                pc_d = next_pc;
            end

            if (is_pop && ras_empty) begin
                under_d = 1'b1;
            end
        end

        case ({do_push, do_pop})
            2'b10: begin
                ptr_d = ptr_q + PW'(1);
                cnt_d = ras_full ? cnt_q : cnt_q + CW'(1);
            end
            2'b01: begin
                ptr_d = top_idx;
                cnt_d = cnt_q - CW'(1);
            end
            default: begin
                ptr_d = ptr_q;
                cnt_d = cnt_q;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_VECTOR;
            epc_q   <= '0;
            align_q <= 1'b0;
            under_q <= 1'b0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            align_q <= align_d;
            under_q <= under_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Stack storage is not reset; the count alone defines validity
    always_ff @(posedge clk) begin
        if (do_push) begin
            stack_q[wr_idx] <= pc_plus4;
        end
    end

    assign pc            = pc_q;
    assign epc           = epc_q;
    assign align_fault   = align_q;
    assign ras_underflow = under_q;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised successor to the 4-way PC source mux for the multicycle CPU.
- Owns the PC register and computes all candidate targets internally: sequential, branch, register, jump, trap and return-stack pop.
- Adds a small return-address stack, an alignment trap and EPC capture.
- Sits between the control FSM (pc_write, pc_src) and instruction memory address.

Parameters:
- WIDTH, 32, PC/address width; legal range 32..64.
- RESET_VECTOR, 0, PC value on reset.
- TRAP_VECTOR, 32'h0000_0040, PC loaded on alignment fault or pc_src=110; zero-extended to WIDTH.
- RAS_DEPTH, 4, return-address stack entries; power of two, 2..16.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- pc_write  input  1  commit next_pc to PC this cycle.
- pc_src  input  3  000 seq, 001 branch, 010 register, 011 jump, 100 RAS pop, 110 trap; 101/111 reserved and treated as 000.
- branch_taken  input  1  branch condition from ALU zero logic; used only when pc_src=001.
- offset  input  16  signed word offset for branch.
- reg_target  input  WIDTH  jump-register target.
- jump_index  input  26  jump instruction index.
- ras_push  input  1  push pc_plus4 when pc_write=1.
- fault_clear  input  1  clears sticky flags.
- pc  output  WIDTH  current PC.
- pc_plus4  output  WIDTH  pc+4, combinational.
- next_pc  output  WIDTH  selected target, combinational, before fault override.
- epc  output  WIDTH  faulting target or PC captured on trap.
- align_fault  output  1  sticky misaligned-target flag.
- ras_underflow  output  1  sticky pop-on-empty flag.
- ras_empty  output  1  stack empty.
- ras_full  output  1  stack full.

Behaviour:
- Reset (async, immediate): pc=RESET_VECTOR, epc=0, align_fault=0, ras_underflow=0, ras count=0, ras_empty=1, ras_full=0. Stack contents are don't-care.
- Arithmetic: all target arithmetic is mod 2^WIDTH.
  - pc_plus4 = pc+4.
  - Branch target = pc_plus4 + (sign_extend(offset) << 2).
  - Jump target = {pc_plus4[WIDTH-1:28], jump_index, 2'b00}.
- next_pc selection:
  - 001 with branch_taken=0 selects pc_plus4.
  - 100 selects the stack top, or pc_plus4 when the stack is empty.
  - 110 selects TRAP_VECTOR.
- PC update, with pc_write=1 at a rising edge:
  - If next_pc[1:0]!=0: pc<=TRAP_VECTOR, epc<=next_pc, align_fault<=1.
  - Else if pc_src=110: pc<=TRAP_VECTOR, epc<=pc.
  - Else: pc<=next_pc.
- With pc_write=0, all registers hold; push and pop are ignored. Latency: one edge from pc_write to new pc.
- RAS push, on pc_write & ras_push: write pc_plus4 at top and increment count. When full, the oldest entry is overwritten (circular) and count stays at RAS_DEPTH.
- RAS pop, on pc_write & pc_src=100: decrement count. When empty, count stays 0, ras_underflow<=1 and pc takes pc_plus4.
- Simultaneous push and pop: the pop target is the old top; the top entry is replaced by pc_plus4 and count is unchanged.
- An alignment fault on a pop still pops. An alignment fault with ras_push still pushes.
- fault_clear clears align_fault and ras_underflow at the edge. A simultaneous new fault wins (flag stays 1).
- rst mid-operation discards any pending commit; the stack count returns to 0.

Test Plan:
- Reset then 3 commits with pc_src=000 → pc goes 0x0, 0x4, 0x8, 0xC. pc_write=0 for 2 cycles → pc holds 0xC.
- pc=0x100, pc_src=001, offset=16'hFFFE, branch_taken=1 → pc=0xFC. Same with branch_taken=0 → pc=0x104.
- pc=0x4000_0010, pc_src=011, jump_index=26'h000_0040 → pc=0x4000_0100. pc_src=010 with reg_target=0x203 → pc=0x40, epc=0x203, align_fault=1. fault_clear → align_fault=0.
- RAS_DEPTH=4: 5 pushes at pc=0x0,0x10,0x20,0x30,0x40 → ras_full=1. 4 pops return 0x44, 0x34, 0x24, 0x14. 5th pop → ras_underflow=1, pc=pc+4.
- Push and pop in the same commit at pc=0x80 with top=0x14 → pc=0x14, new top=0x84, count unchanged.
- Assert rst during a committing cycle with the stack non-empty → pc=RESET_VECTOR immediately, ras_empty=1, flags=0.
